// File: rtl/lidar_scan_pkg.sv
// Shared sweep FSM states and default servo timing for the lidar scan path.
// Timing values are in clk cycles at 100 MHz.
package lidar_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_ADVANCE
  } sweep_state_t;

  localparam int unsigned DEF_MIN_PULSE     = 100000;
  localparam int unsigned DEF_MAX_PULSE     = 200000;
  localparam int unsigned DEF_STEP          = 10000;
  localparam int unsigned DEF_SETTLE_CYCLES = 2000000;
  localparam int unsigned DEF_ACK_TIMEOUT   = 1000000;

endpackage

// File: rtl/cycle_timer.sv
// Up-counter restarted by i_load. o_done marks the cycle on which the count
// reaches i_limit-1, so a state that loads the timer on entry lasts i_limit cycles.
module cycle_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic [31:0] i_limit,
  output logic        o_done
);

  logic [31:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 32'd1;
    end
  end

  assign o_done = (r_count == (i_limit - 32'd1));

endmodule

// File: rtl/servo_sweep_sequencer.sv
// Bounces a servo pulse width between MIN_PULSE and MAX_PULSE in STEP increments,
// settling and handshaking one range sample at every position.
module servo_sweep_sequencer
  import lidar_scan_pkg::*;
#(
  parameter int unsigned MIN_PULSE     = DEF_MIN_PULSE,
  parameter int unsigned MAX_PULSE     = DEF_MAX_PULSE,
  parameter int unsigned STEP          = DEF_STEP,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned ACK_TIMEOUT   = DEF_ACK_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        sample_ack,
  output logic [31:0] angle_requested,
  output logic        sample_req,
  output logic [7:0]  step_index,
  output logic        sweep_dir,
  output logic        sweep_done,
  output logic        sample_timeout
);

  localparam logic [31:0] L_MIN     = 32'(MIN_PULSE);
  localparam logic [31:0] L_MAX     = 32'(MAX_PULSE);
  localparam logic [31:0] L_STEP    = 32'(STEP);
  localparam logic [31:0] L_SETTLE  = 32'(SETTLE_CYCLES);
  localparam logic [31:0] L_TIMEOUT = 32'(ACK_TIMEOUT);

  sweep_state_t r_state, w_next_state;
  logic [31:0]  r_angle, w_angle_next, w_timer_limit;
  logic [7:0]   r_index, w_index_next;
  logic         r_dir, w_dir_next;
  logic         r_done, w_done_next;
  logic         r_timeout, w_timeout_next;
  logic         w_timer_load, w_timer_done;
  logic         w_hit_max, w_hit_min;

  cycle_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_timer_load),
    .i_limit (w_timer_limit),
    .o_done  (w_timer_done)
  );

  // End-stop tests carried out in 33 bits so neither side can wrap.
  assign w_hit_max = ({1'b0, r_angle} + {1'b0, L_STEP}) > {1'b0, L_MAX};
  assign w_hit_min = {1'b0, r_angle} < ({1'b0, L_MIN} + {1'b0, L_STEP});

  always_comb begin
    w_next_state   = r_state;
    w_timer_load   = 1'b0;
    w_timer_limit  = L_SETTLE;
    w_angle_next   = r_angle;
    w_index_next   = r_index;
    w_dir_next     = r_dir;
    w_done_next    = 1'b0;
    w_timeout_next = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable) begin
          w_next_state = ST_SETTLE;
          w_timer_load = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (!enable) begin
          w_next_state = ST_IDLE;
        end else if (w_timer_done) begin
          w_next_state = ST_SAMPLE;
          w_timer_load = 1'b1;
        end
      end
      ST_SAMPLE: begin
        w_timer_limit = L_TIMEOUT;
        // An ack landing on the expiry cycle still counts as a good sample.
        if (sample_ack) begin
          w_next_state = ST_ADVANCE;
        end else if (w_timer_done) begin
          w_next_state   = ST_ADVANCE;
          w_timeout_next = 1'b1;
        end
      end
      ST_ADVANCE: begin
        if (r_dir ? w_hit_max : w_hit_min) begin
          w_dir_next  = ~r_dir;
          w_done_next = 1'b1;
        end
        if (w_dir_next) begin
          w_angle_next = r_angle + L_STEP;
          w_index_next = r_index + 8'd1;
        end else begin
          w_angle_next = r_angle - L_STEP;
          w_index_next = r_index - 8'd1;
        end
        w_next_state = enable ? ST_SETTLE : ST_IDLE;
        w_timer_load = enable;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_angle   <= L_MIN;
      r_index   <= '0;
      r_dir     <= 1'b1;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_angle   <= w_angle_next;
      r_index   <= w_index_next;
      r_dir     <= w_dir_next;
      r_done    <= w_done_next;
      r_timeout <= w_timeout_next;
    end
  end

  assign angle_requested = r_angle;
  assign step_index      = r_index;
  assign sweep_dir       = r_dir;
  assign sweep_done      = r_done;
  assign sample_timeout  = r_timeout;
  assign sample_req      = (r_state == ST_SAMPLE);

endmodule

// File: tb/tb_servo_sweep_sequencer.sv
// Bench for servo_sweep_sequencer with reduced timing; a second instance with an
// unaligned MAX_PULSE shares every input and is checked alongside the first.
module tb_servo_sweep_sequencer;

  localparam int MINP   = 100;
  localparam int MAXP   = 140;
  localparam int MAXP2  = 135;
  localparam int STEPP  = 10;
  localparam int SETTLE = 20;
  localparam int TMO    = 50;
  localparam int K1     = (MAXP - MINP) / STEPP;
  localparam int K2     = (MAXP2 - MINP) / STEPP;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        sample_ack = 1'b0;
  logic [31:0] angle, angle2;
  logic [7:0]  idx, idx2;
  logic        req, req2, dir, dir2, done, done2, tmo, tmo2;

  int errors = 0;
  int checks = 0;
  int nSteps = 0;
  int maxAngle2 = 0;
  bit monitorOn = 1'b0;

  always #5 clk = ~clk;

  servo_sweep_sequencer #(
    .MIN_PULSE(MINP), .MAX_PULSE(MAXP), .STEP(STEPP),
    .SETTLE_CYCLES(SETTLE), .ACK_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .sample_ack(sample_ack),
    .angle_requested(angle), .sample_req(req), .step_index(idx),
    .sweep_dir(dir), .sweep_done(done), .sample_timeout(tmo)
  );

  servo_sweep_sequencer #(
    .MIN_PULSE(MINP), .MAX_PULSE(MAXP2), .STEP(STEPP),
    .SETTLE_CYCLES(SETTLE), .ACK_TIMEOUT(TMO)
  ) dut135 (
    .clk(clk), .reset(reset), .enable(enable), .sample_ack(sample_ack),
    .angle_requested(angle2), .sample_req(req2), .step_index(idx2),
    .sweep_dir(dir2), .sweep_done(done2), .sample_timeout(tmo2)
  );

  // Reference: after n completed positions the sweep is a triangle wave of period 2k.
  function automatic int posOf(int n, int k);
    int m = n % (2 * k);
    return (m <= k) ? m : 2 * k - m;
  endfunction

  function automatic bit upOf(int n, int k);
    int m = n % (2 * k);
    return (n == 0) || (m >= 1 && m <= k);
  endfunction

  function automatic bit revAt(int n, int k);
    int m = n % (2 * k);
    return (m == k) || (m == 0 && n > 0);
  endfunction

  function automatic logic [31:0] angleOf(int n, int k);
    return 32'(MINP + STEPP * posOf(n, k));
  endfunction

  always @(negedge clk) begin
    if (monitorOn) begin
      if (int'(angle2) > maxAngle2) maxAngle2 = int'(angle2);
      checks++;
      if (angle < 32'(MINP) || angle > 32'(MAXP) || angle2 < 32'(MINP) || angle2 > 32'(MAXP2)) begin
        errors++;
        $display("[TB] FAIL angle_range: got %0d / %0d required within [%0d,%0d] / [%0d,%0d]",
                 angle, angle2, MINP, MAXP, MINP, MAXP2);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitReq(output int n);
    n = 0;
    while (!req && n < 200) begin
      tick();
      n++;
    end
    if (!req) n = -1;
  endtask

  task automatic applyReset();
    reset = 1'b1;
    sample_ack = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    nSteps = 0;
  endtask

  task automatic test_reset();
    enable = 1'b0;
    applyReset();
    monitorOn = 1'b1;
    checks++;
    if ({angle, idx, dir, req, done, tmo} !== {32'd100, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_state: got angle=%0d idx=%0d dir=%0b req=%0b done=%0b tmo=%0b required 100 0 1 0 0 0",
               angle, idx, dir, req, done, tmo);
    end
    checks++;
    if ({angle2, idx2, dir2, req2} !== {32'd100, 8'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_state_135: got angle=%0d idx=%0d dir=%0b req=%0b required 100 0 1 0",
               angle2, idx2, dir2, req2);
    end
    repeat (40) tick();
    checks++;
    if (req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_no_enable: got req=%0b required 0", req);
    end
  endtask

  task automatic test_sweep(input int count, input bit randomAck, input int firstLat);
    int n;
    int d;
    bit rev1;
    bit rev2;
    enable = 1'b1;
    for (int s = 0; s < count; s++) begin
      waitReq(n);
      checks++;
      if (n != ((s == 0) ? firstLat : SETTLE)) begin
        errors++;
        $display("[TB] FAIL settle_latency: got %0d required %0d", n, (s == 0) ? firstLat : SETTLE);
      end
      checks++;
      if ({angle, idx, dir} !== {angleOf(nSteps, K1), 8'(posOf(nSteps, K1)), upOf(nSteps, K1)}) begin
        errors++;
        $display("[TB] FAIL sample_position: got angle=%0d idx=%0d dir=%0b required %0d %0d %0b",
                 angle, idx, dir, angleOf(nSteps, K1), posOf(nSteps, K1), upOf(nSteps, K1));
      end
      checks++;
      if ({angle2, idx2, dir2} !== {angleOf(nSteps, K2), 8'(posOf(nSteps, K2)), upOf(nSteps, K2)}) begin
        errors++;
        $display("[TB] FAIL sample_position_135: got angle=%0d idx=%0d dir=%0b required %0d %0d %0b",
                 angle2, idx2, dir2, angleOf(nSteps, K2), posOf(nSteps, K2), upOf(nSteps, K2));
      end
      d = randomAck ? int'($urandom_range(0, TMO - 2)) : 3;
      repeat (d) tick();
      sample_ack = 1'b1;
      tick();
      sample_ack = 1'b0;
      checks++;
      if ({req, tmo, done, req2, tmo2, done2} !== 6'b0) begin
        errors++;
        $display("[TB] FAIL ack_handshake: got req=%0b tmo=%0b done=%0b req2=%0b tmo2=%0b done2=%0b required all 0",
                 req, tmo, done, req2, tmo2, done2);
      end
      rev1 = revAt(nSteps, K1);
      rev2 = revAt(nSteps, K2);
      nSteps++;
      tick();
      checks++;
      if ({angle, idx, dir, done} !== {angleOf(nSteps, K1), 8'(posOf(nSteps, K1)), upOf(nSteps, K1), rev1}) begin
        errors++;
        $display("[TB] FAIL advance: got angle=%0d idx=%0d dir=%0b done=%0b required %0d %0d %0b %0b",
                 angle, idx, dir, done, angleOf(nSteps, K1), posOf(nSteps, K1), upOf(nSteps, K1), rev1);
      end
      checks++;
      if ({angle2, idx2, dir2, done2} !== {angleOf(nSteps, K2), 8'(posOf(nSteps, K2)), upOf(nSteps, K2), rev2}) begin
        errors++;
        $display("[TB] FAIL advance_135: got angle=%0d idx=%0d dir=%0b done=%0b required %0d %0d %0b %0b",
                 angle2, idx2, dir2, done2, angleOf(nSteps, K2), posOf(nSteps, K2), upOf(nSteps, K2), rev2);
      end
    end
  endtask

  task automatic test_timeout();
    int n;
    int k;
    enable = 1'b0;
    applyReset();
    enable = 1'b1;
    waitReq(n);
    k = 0;
    while (req && k < 200) begin
      tick();
      k++;
    end
    checks++;
    if (k != TMO || tmo !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_pulse: got wait=%0d tmo=%0b required %0d 1", k, tmo, TMO);
    end
    nSteps++;
    tick();
    checks++;
    if ({tmo, angle, idx} !== {1'b0, 32'd110, 8'd1}) begin
      errors++;
      $display("[TB] FAIL timeout_advance: got tmo=%0b angle=%0d idx=%0d required 0 110 1", tmo, angle, idx);
    end
  endtask

  task automatic test_ack_on_expiry();
    int n;
    waitReq(n);
    repeat (TMO - 1) tick();
    checks++;
    if (req !== 1'b1) begin
      errors++;
      $display("[TB] FAIL expiry_still_waiting: got req=%0b required 1", req);
    end
    sample_ack = 1'b1;
    tick();
    sample_ack = 1'b0;
    checks++;
    if ({req, tmo} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL ack_wins_expiry: got req=%0b tmo=%0b required 0 0", req, tmo);
    end
    nSteps++;
    tick();
    checks++;
    if (angle !== angleOf(nSteps, K1)) begin
      errors++;
      $display("[TB] FAIL expiry_advance: got %0d required %0d", angle, angleOf(nSteps, K1));
    end
  endtask

  task automatic test_stray_ack();
    int n;
    sample_ack = 1'b1;
    repeat (10) tick();
    sample_ack = 1'b0;
    waitReq(n);
    checks++;
    if (n != SETTLE - 10 || angle !== angleOf(nSteps, K1)) begin
      errors++;
      $display("[TB] FAIL stray_ack: got wait=%0d angle=%0d required %0d %0d",
               n, angle, SETTLE - 10, angleOf(nSteps, K1));
    end
    sample_ack = 1'b1;
    tick();
    sample_ack = 1'b0;
    nSteps++;
    tick();
  endtask

  task automatic test_disable_in_settle();
    int n;
    enable = 1'b0;
    applyReset();
    test_sweep(2, 1'b0, SETTLE + 1);
    repeat (5) tick();
    enable = 1'b0;
    tick();
    checks++;
    if ({req, angle} !== {1'b0, 32'd120}) begin
      errors++;
      $display("[TB] FAIL settle_abort: got req=%0b angle=%0d required 0 120", req, angle);
    end
    repeat (40) tick();
    checks++;
    if ({req, angle} !== {1'b0, 32'd120}) begin
      errors++;
      $display("[TB] FAIL idle_hold: got req=%0b angle=%0d required 0 120", req, angle);
    end
    enable = 1'b1;
    waitReq(n);
    checks++;
    if (n != SETTLE + 1 || angle !== 32'd120 || idx !== 8'd2) begin
      errors++;
      $display("[TB] FAIL resume: got wait=%0d angle=%0d idx=%0d required %0d 120 2", n, angle, idx, SETTLE + 1);
    end
    sample_ack = 1'b1;
    tick();
    sample_ack = 1'b0;
    nSteps++;
    tick();
  endtask

  task automatic test_disable_in_sample();
    int n;
    waitReq(n);
    enable = 1'b0;
    repeat (4) tick();
    checks++;
    if (req !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sample_not_aborted: got req=%0b required 1", req);
    end
    sample_ack = 1'b1;
    tick();
    sample_ack = 1'b0;
    nSteps++;
    tick();
    repeat (40) tick();
    checks++;
    if ({req, angle} !== {1'b0, angleOf(nSteps, K1)}) begin
      errors++;
      $display("[TB] FAIL advance_then_idle: got req=%0b angle=%0d required 0 %0d", req, angle, angleOf(nSteps, K1));
    end
    enable = 1'b1;
    waitReq(n);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({angle, idx, dir, req, angle2, req2} !== {32'd100, 8'd0, 1'b1, 1'b0, 32'd100, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_mid_sample: got angle=%0d idx=%0d dir=%0b req=%0b angle2=%0d req2=%0b required 100 0 1 0 100 0",
               angle, idx, dir, req, angle2, req2);
    end
    reset = 1'b0;
    nSteps = 0;
    test_sweep(2, 1'b0, SETTLE + 1);
  endtask

  task automatic test_unaligned_max();
    enable = 1'b0;
    applyReset();
    maxAngle2 = 0;
    test_sweep(8, 1'b1, SETTLE + 1);
    checks++;
    if (maxAngle2 != 130) begin
      errors++;
      $display("[TB] FAIL unaligned_peak: got %0d required 130", maxAngle2);
    end
  endtask

  initial begin
    test_reset();
    test_sweep(6, 1'b0, SETTLE + 1);
    test_sweep(14, 1'b1, SETTLE);
    test_timeout();
    test_ack_on_expiry();
    test_stray_ack();
    test_disable_in_settle();
    test_disable_in_sample();
    test_unaligned_max();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
